// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the architectural PC, issues word fetches to a
// variable-latency instruction memory and presents the fetched instruction to
// the datapath until it is acknowledged, at which point next_pc is committed.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        instr_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        fetch_err,
  output logic [31:0] instr_count
);

  // The counter only has to reach MEM_TIMEOUT-1.
  localparam int unsigned CntW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StReq,
    StValid,
    StErr
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     count_q, count_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next-state logic: fetch, present, commit, or lock up on error.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StReq: begin
        // A capture wins over the timeout limit in the same cycle.
        if (mem_ready) begin
          instr_d = mem_rdata;
          cnt_d   = '0;
          state_d = StValid;
        end else if (cnt_q == CntLimit) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StValid: begin
        if (instr_ack) begin
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            count_d = count_q + 32'd1;
            state_d = StReq;
          end else begin
            state_d = StErr;
          end
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StErr;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from state; mem_req is gated so it drops while reset is held.
  always_comb begin
    mem_req     = reset && (state_q == StReq);
    instr_valid = (state_q == StValid);
    fetch_err   = (state_q == StErr);
    mem_addr    = pc_q;
    pc          = pc_q;
    pc4         = pc_q + 32'd4;
    instr       = instr_q;
    instr_count = count_q;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit: the consumer of the next-PC value produced by the datapath select logic. It holds the architectural PC and issues word fetches to an instruction memory with variable latency. It presents the fetched instruction to the datapath and loads the committed next_pc when the datapath acknowledges the instruction. It is the first sequential stage ahead of decode in the multi-cycle core.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset (MARS text base)
MEM_TIMEOUT, 16, maximum cycles allowed in REQ before the fetch is declared failed

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 = reset
next_pc  in  32  PC to load on commit (branch/jump/jr/PC+4 already selected by the datapath)
instr_ack  in  1  datapath has consumed instr; commits next_pc
mem_req  out  1  fetch request to instruction memory
mem_addr  out  32  word address of the fetch; equals pc
mem_ready  in  1  memory returns mem_rdata this cycle
mem_rdata  in  32  fetched instruction word
instr  out  32  registered instruction word
instr_valid  out  1  instr and pc are valid for the datapath
pc  out  32  PC of the presented instruction
pc4  out  32  pc+4, modulo 2^32
fetch_err  out  1  sticky error: misaligned next_pc or memory timeout
instr_count  out  32  number of committed instructions

Behaviour:
- Reset (reset=0, asynchronous, overrides everything, including mid-REQ):
  - pc=RESET_PC, instr=0, instr_valid=0, fetch_err=0, instr_count=0, timeout counter=0, state=REQ.
  - mem_req is deasserted while reset=0.
- States: REQ, VALID, ERR.
- REQ:
  - mem_req=1, mem_addr=pc.
  - If mem_ready=1: instr<=mem_rdata, timeout counter<=0, next state VALID. A zero-wait memory therefore gives instr_valid one cycle after mem_req rises.
  - Else: timeout counter increments. When the counter reaches MEM_TIMEOUT-1 without mem_ready, go to ERR.
  - instr_ack in REQ is ignored.
- VALID:
  - instr_valid=1, mem_req=0. instr and pc are held stable until acknowledged.
  - On instr_ack=1 with next_pc[1:0]==0: pc<=next_pc, instr_count<=instr_count+1 (wraps at 2^32), next state REQ. instr_valid drops the next cycle.
  - On instr_ack=1 with next_pc[1:0]!=0: go to ERR; pc unchanged; instr_count not incremented.
  - mem_ready in VALID is ignored.
- ERR:
  - fetch_err=1, mem_req=0, instr_valid=0. pc and instr hold their last values.
  - The only exit is reset.
- Combinational outputs:
  - mem_addr=pc at all times.
  - pc4=pc+4, 32-bit wrap (pc=32'hFFFF_FFFC gives pc4=0).
- Throughput: at best one instruction per 2 cycles (REQ then VALID) with a zero-wait memory.
- Simultaneous events: mem_ready and the timeout limit in the same cycle resolve to the capture, not ERR.

Test Plan:
- Reset then zero-wait memory (mem_ready=1 always), mem_rdata=32'h2408_0001 -> cycle 1 after reset release: mem_req=1, mem_addr=32'h0000_3000; cycle 2: instr_valid=1, instr=32'h2408_0001, pc4=32'h0000_3004.
- Ack with next_pc=32'h0000_3010 -> next cycle pc=32'h0000_3010, mem_addr=32'h0000_3010, instr_count=1, instr_valid=0.
- Memory with 3 wait cycles -> mem_req held high for 4 cycles with a stable mem_addr; instr_valid rises on the cycle after mem_ready; no ERR.
- mem_ready held low for 16 cycles in REQ -> fetch_err=1, mem_req=0; further instr_ack and mem_ready pulses have no effect until reset.
- Ack with next_pc=32'h0000_3006 -> fetch_err=1, pc stays at its previous value, instr_count unchanged.
- Assert reset=0 mid-REQ with mem_ready low -> pc, instr_valid and fetch_err clear immediately without waiting for a clock edge; after release, the fetch restarts at 32'h0000_3000 and instr_count=0.
